// File: rtl/neighbor_count.sv
// neighbor_count: walks an NxM mine board in raster order and writes each cell's neighbour mine count.
// Optional macro NEIGHBOR_COUNT_MINE_MARK_EN adds a CENTER state so mine cells are written as 9.
module neighbor_count #(
    parameter int boardWidth  = 8,
    parameter int boardHeight = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           ack,
    output logic [$clog2(boardWidth)-1:0]  x,
    output logic [$clog2(boardHeight)-1:0] y,
    input  logic                           mineBoardReadValue,
    output logic [$clog2(boardWidth)-1:0]  writeX,
    output logic [$clog2(boardHeight)-1:0] writeY,
    output logic [3:0]                     countOut,
    output logic                           countWriteEn,
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
    output logic                           center,
`endif
    output logic                           init,
    output logic                           scan,
    output logic                           writeCell,
    output logic                           done
);
    localparam int XW = $clog2(boardWidth);
    localparam int YW = $clog2(boardHeight);
    localparam logic [XW-1:0] X_MAX = XW'(boardWidth - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(boardHeight - 1);

`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
    typedef enum logic [2:0] {S_INIT, S_CENTER, S_SCAN, S_WRITE, S_DONE} state_t;
    localparam state_t S_FIRST = S_CENTER;
    logic mine_q, mine_d;
`else
    typedef enum logic [1:0] {S_INIT, S_SCAN, S_WRITE, S_DONE} state_t;
    localparam state_t S_FIRST = S_SCAN;
`endif

    state_t        state_q, state_d;
    logic [XW-1:0] cx_q, cx_d, nx;
    logic [YW-1:0] cy_q, cy_d, ny;
    logic [2:0]    k_q, k_d;
    logic [3:0]    acc_q, acc_d;
    logic          dx_neg, dx_pos, dy_neg, dy_pos, in_b, last_cell;

    // Neighbour order k=0..7: row above (left..right), left, right, row below (left..right)
    always_comb begin
        dx_neg    = (k_q == 3'd0) || (k_q == 3'd3) || (k_q == 3'd5);
        dx_pos    = (k_q == 3'd2) || (k_q == 3'd4) || (k_q == 3'd7);
        dy_neg    = k_q < 3'd3;
        dy_pos    = k_q > 3'd4;
        in_b      = !(dx_neg && cx_q == '0) && !(dx_pos && cx_q == X_MAX) &&
                    !(dy_neg && cy_q == '0) && !(dy_pos && cy_q == Y_MAX);
        nx        = cx_q + XW'(dx_pos) - XW'(dx_neg);
        ny        = cy_q + YW'(dy_pos) - YW'(dy_neg);
        last_cell = (cx_q == X_MAX) && (cy_q == Y_MAX);
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        k_d     = k_q;
        acc_d   = acc_q;
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
        mine_d  = mine_q;
`endif
        case (state_q)
            S_INIT: begin
                cx_d  = '0;
                cy_d  = '0;
                k_d   = '0;
                acc_d = '0;
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
                mine_d = 1'b0;
`endif
                state_d = start ? S_FIRST : S_INIT;
            end
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
            S_CENTER: begin
                mine_d  = mineBoardReadValue;
                state_d = S_SCAN;
            end
`endif
            S_SCAN: begin
                acc_d   = acc_q + {3'b000, in_b & mineBoardReadValue};
                k_d     = k_q + 3'd1;
                state_d = (k_q == 3'd7) ? S_WRITE : S_SCAN;
            end
            S_WRITE: begin
                if (last_cell) begin
                    state_d = S_DONE;
                end else begin
                    cx_d    = (cx_q == X_MAX) ? '0 : cx_q + XW'(1);
                    cy_d    = (cx_q == X_MAX) ? cy_q + YW'(1) : cy_q;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_FIRST;
                end
            end
            S_DONE: begin
                // Clear on leaving so INIT shows the reset-like output view
                if (ack) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    acc_d   = '0;
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
                    mine_d  = 1'b0;
`endif
                    state_d = S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            cx_q    <= '0;
            cy_q    <= '0;
            k_q     <= '0;
            acc_q   <= '0;
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
            mine_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
            mine_q  <= mine_d;
`endif
        end
    end

    always_comb begin
        x            = (state_q == S_SCAN && in_b) ? nx : cx_q;
        y            = (state_q == S_SCAN && in_b) ? ny : cy_q;
        writeX       = cx_q;
        writeY       = cy_q;
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
        countOut     = mine_q ? 4'd9 : acc_q;
        center       = state_q == S_CENTER;
`else
        countOut     = acc_q;
`endif
        countWriteEn = state_q == S_WRITE;
        init         = state_q == S_INIT;
        scan         = state_q == S_SCAN;
        writeCell    = state_q == S_WRITE;
        done         = state_q == S_DONE;
    end
endmodule

// File: tb/tb_neighbor_count.sv
// tb_neighbor_count: directed passes over several mine boards; every count write is checked against a scoreboard.
module tb_neighbor_count;
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
    localparam bit MARK = 1'b1;
    localparam int PER  = 10;
`else
    localparam bit MARK = 1'b0;
    localparam int PER  = 9;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic [2:0]  x, y, writeX, writeY;
    logic [3:0]  countOut;
    logic        countWriteEn, init, scan, writeCell, done, first_st;
    logic [63:0] board = '0;
    logic        mineBoardReadValue;
    logic [9:0]  sb[$];
    int          total = 0;
    int          bad = 0;

    assign mineBoardReadValue = board[{y, x}];

`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
    logic center;
    assign first_st = center;
`else
    assign first_st = scan;
`endif

    neighbor_count dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack),
        .x(x), .y(y), .mineBoardReadValue(mineBoardReadValue),
        .writeX(writeX), .writeY(writeY), .countOut(countOut), .countWriteEn(countWriteEn),
`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
        .center(center),
`endif
        .init(init), .scan(scan), .writeCell(writeCell), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model(input int cx, input int cy);
        int c = 0;
        if (MARK && board[cy*8+cx]) return 4'd9;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if ((dx != 0 || dy != 0) && cx+dx >= 0 && cx+dx < 8 && cy+dy >= 0 && cy+dy < 8)
                    c += int'(board[(cy+dy)*8+(cx+dx)]);
        return 4'(c);
    endfunction

    task automatic load_expect();
        for (int cy = 0; cy < 8; cy++)
            for (int cx = 0; cx < 8; cx++)
                sb.push_back({3'(cx), 3'(cy), model(cx, cy)});
    endtask

    // Counts edges from the one that sampled start until done rises
    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk(tag, n, 64 * PER);
        chk("sb_empty", sb.size(), 0);
        chk("done_wen", countWriteEn, 0);
    endtask

    task automatic finish_pass();
        @(negedge clk) ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        chk("ack_init", init, 1);
        chk("init_wx", writeX, 0);
    endtask

    task automatic do_pass(input logic [63:0] b, input string tag);
        board = b;
        load_expect();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag);
        finish_pass();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("onehot", $countones({init, scan, writeCell, done, first_st && !scan}), 1);
            if (countWriteEn)
                chk("write", {writeX, writeY, countOut}, sb.size() != 0 ? sb.pop_front() : 10'h3ff);
        end
    end

    initial begin
        logic [63:0] rb;
        #3;
        chk("rst_init", init, 1);
        chk("rst_wen", countWriteEn, 0);
        chk("rst_xy", {x, y}, 0);
        chk("rst_wxy", {writeX, writeY}, 0);
        chk("rst_cnt", countOut, 0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_init", init, 1);

        // Empty board, with an ack pulse mid-pass that must be ignored
        board = '0;
        load_expect();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        chk("ack_ignored", init, 0);
        begin
            int n = 6;
            while (!done && n < 2000) begin
                @(posedge clk);
                n++;
                #1;
            end
            chk("empty_done_cyc", n, 64 * PER);
        end
        chk("empty_sb", sb.size(), 0);
        finish_pass();

        do_pass(64'(1) << (4*8+3), "single_mine");
        do_pass((64'(1) << 0) | (64'(1) << 1) | (64'(1) << 8), "corner_mines");
        do_pass({64{1'b1}}, "all_mined");
        rb = {$urandom, $urandom};
        do_pass(rb, "random_board");

        // Reset mid-pass, then a full restart from (0,0)
        board = {$urandom, $urandom};
        load_expect();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (99) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_init", init, 1);
        chk("midrst_wen", countWriteEn, 0);
        chk("midrst_wxy", {writeX, writeY, countOut}, 0);
        sb.delete();
        @(negedge clk) reset = 1'b1;
        do_pass(board, "restart_pass");

        // start held through DONE; ack with start high starts a new pass
        board = {$urandom, $urandom};
        load_expect();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        wait_done("held_done_cyc");
        repeat (5) @(posedge clk);
        #1 chk("held_in_done", done, 1);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        chk("held_ack_init", init, 1);
        load_expect();
        @(posedge clk);
        #1 chk("held_restart", first_st, 1);
        start = 1'b0;
        wait_done("held_pass2_cyc");
        finish_pass();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
